fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter PC_W, default 10, program-counter and branch-target width in bits.
REQ-002: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003: Reset  input  1  asynchronous, active-high reset.
REQ-004: Start  input  1  begin (or restart) execution at StartAddr.
REQ-005: StartAddr  input  PC_W  first instruction address.
REQ-006: BranchEn  input  1  current instruction at PC is a branch.
REQ-007: BranchOp  input  3  branch encoding from the definitions package: kBEA, kBER, kBNA, kBNR, kBUN.
REQ-008: Flag  input  1  equality flag produced by the last kCMP; 1 = equal.
REQ-009: Target  input  PC_W  absolute address (kBEA/kBNA/kBUN) or two's-complement offset (kBER/kBNR).
REQ-010: Stall  input  1  hold PC this cycle.
REQ-011: HaltReq  input  1  current instruction is the program-end instruction.
REQ-012: PC  output  PC_W  instruction-memory address, registered.
REQ-013: InstrValid  output  1  PC addresses a live instruction (state RUN).
REQ-014: Taken  output  1  registered one-cycle pulse: the previous RUN cycle took a branch.
REQ-015: BadOp  output  1  registered one-cycle pulse: previous RUN cycle had BranchEn with an undefined BranchOp.
REQ-016: Done  output  1  high while in state HALT.

Function
REQ-017: FSM states IDLE, RUN, HALT; encoding is free.
REQ-018: IDLE: PC holds, InstrValid=0, Done=0; Start=1 -> RUN with PC<=StartAddr next edge.
REQ-019: RUN: InstrValid=1; evaluated per edge in strict priority: Start, HaltReq, Stall, branch, increment.
REQ-020: RUN with Start=1 -> PC<=StartAddr, remain RUN (restart).
REQ-021: RUN with HaltReq=1 -> HALT, PC holds; HaltReq overrides Stall and BranchEn.
REQ-022: RUN with Stall=1 -> PC holds; BranchEn ignored; Taken/BadOp drive 0 next cycle.
REQ-023: Branch conditions: kBEA taken iff Flag=1, absolute; kBER taken iff Flag=1, relative; kBNA taken iff Flag=0, absolute; kBNR taken iff Flag=0, relative; kBUN always taken, absolute.
REQ-024: Absolute taken -> PC<=Target; relative taken -> PC<=(PC+Target) mod 2^PC_W, Target read as signed.
REQ-025: Not-taken branch or BranchEn=0 -> PC<=(PC+1) mod 2^PC_W; PC=2^PC_W-1 wraps to 0.
REQ-026: BranchEn=1 with BranchOp in {3'b101,3'b110,3'b111} -> treated as not taken, PC increments, BadOp pulses next cycle.
REQ-027: Taken=1 for exactly the cycle after an edge on which a branch was taken; 0 otherwise.
REQ-028: HALT: Done=1, InstrValid=0, PC holds last address; Start=1 -> RUN with PC<=StartAddr, Done drops same edge.
REQ-029: Inputs other than Start ignored in IDLE and HALT.
REQ-030: Outputs are pure functions of registered state; no combinational input-to-output path.

Reset
REQ-031: Reset=1 asynchronously forces state IDLE, PC=0, Taken=0, BadOp=0, Done=0, InstrValid=0, regardless of Clk.
REQ-032: Reset asserted mid-RUN or mid-HALT discards all progress; after release the block waits in IDLE for Start.
REQ-033: Start sampled on the same edge Reset deasserts is honoured only if Reset is already low at that edge.

Verification
REQ-034: Reset, Start=1 StartAddr=10'd20, then 3 idle cycles -> PC 20,21,22,23; InstrValid=1; Taken=0.
REQ-035: PC=10'd100, BranchEn=1 BranchOp=kBER Flag=1 Target=10'h3FC (-4) -> next PC=96, Taken=1 one cycle; same with Flag=0 -> PC=101, Taken=0.
REQ-036: PC=10'd1023, BranchEn=0 -> PC=0; PC=10'd1020, kBNR Flag=0 Target=10'd8 -> PC=4 (wrap).
REQ-037: PC=10'd50, Stall=1 with kBUN Target=10'd7 for 2 cycles -> PC stays 50; Stall drops -> PC=7, Taken=1.
REQ-038: PC=10'd60, HaltReq=1 with kBUN Target=10'd0 -> HALT, PC=60, Done=1, InstrValid=0; Start StartAddr=10'd5 -> PC=5, Done=0.
REQ-039: BranchOp=3'b110 BranchEn=1 at PC=10'd9 -> PC=10, BadOp=1 one cycle; Reset pulse mid-RUN between edges -> PC=0, IDLE immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT with conditional absolute/relative branches.
// One-edge latency from inputs to PC; Stall holds PC and suppresses Taken/BadOp for that cycle.
package fetch_sequencer_pkg;
    localparam logic [2:0] kBEA = 3'd0;
    localparam logic [2:0] kBER = 3'd1;
    localparam logic [2:0] kBNA = 3'd2;
    localparam logic [2:0] kBNR = 3'd3;
    localparam logic [2:0] kBUN = 3'd4;
endpackage

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            BranchEn,
    input  logic [2:0]      BranchOp,
    input  logic            Flag,
    input  logic [PC_W-1:0] Target,
    input  logic            Stall,
    input  logic            HaltReq,
    output logic [PC_W-1:0] PC,
    output logic            InstrValid,
    output logic            Taken,
    output logic            BadOp,
    output logic            Done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]      state;
    logic [1:0]      nxt_state;
    logic [PC_W-1:0] nxt_pc;
    logic            nxt_taken;
    logic            nxt_bad;
    logic            cond;
    logic            op_defined;
    logic            op_relative;

    always_comb begin
        cond        = 1'b0;
        op_defined  = 1'b1;
        op_relative = 1'b0;
        case (BranchOp)
            kBEA:    cond = Flag;
            kBER:    begin cond = Flag;  op_relative = 1'b1; end
            kBNA:    cond = !Flag;
            kBNR:    begin cond = !Flag; op_relative = 1'b1; end
            kBUN:    cond = 1'b1;
            default: op_defined = 1'b0;
        endcase
    end

    // Priority inside RUN: Start, HaltReq, Stall, branch, increment.
    always_comb begin
        nxt_state = state;
        nxt_pc    = PC;
        nxt_taken = 1'b0;
        nxt_bad   = 1'b0;
        case (state)
            S_RUN: begin
                if (Start) begin
                    nxt_pc = StartAddr;
                end else if (HaltReq) begin
                    nxt_state = S_HALT;
                end else if (!Stall) begin
                    if (BranchEn && op_defined && cond) begin
                        nxt_taken = 1'b1;
                        // Two's-complement add wraps modulo 2^PC_W for negative offsets.
                        nxt_pc    = op_relative ? (PC + Target) : Target;
                    end else begin
                        nxt_bad = BranchEn && !op_defined;
                        nxt_pc  = PC + PC_W'(1);
                    end
                end
            end
            S_IDLE, S_HALT: begin
                if (Start) begin
                    nxt_state = S_RUN;
                    nxt_pc    = StartAddr;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            PC    <= '0;
            Taken <= 1'b0;
            BadOp <= 1'b0;
        end else begin
            state <= nxt_state;
            PC    <= nxt_pc;
            Taken <= nxt_taken;
            BadOp <= nxt_bad;
        end
    end

    assign InstrValid = (state == S_RUN);
    assign Done       = (state == S_HALT);

endmodule
